// File: rtl/core_mem_arbiter.sv
// core_mem_arbiter: shares one memory port between instruction fetch and
// data access. Reads are tagged with their source in an in-order FIFO so
// returning data is steered back to the requester that issued it.
//
// Optional feature macro: CORE_MEM_ARB_RR_EN
//   defined     -> round-robin arbitration on contention (last_q register)
//   not defined -> fixed data-over-fetch priority

package core_mem_arbiter_pkg;

   // Unified memory request payload. rd_en and wr_en are mutually exclusive.
   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] wr_data;
      logic [3:0]  byte_en;
      logic        rd_en;
      logic        wr_en;
   } t_core2mem_req;

endpackage

module core_mem_arbiter
   import core_mem_arbiter_pkg::*;
#(
   parameter int MAX_OUTSTANDING = 2
) (
   input  logic          clk,
   input  logic          rst_n,

   input  logic          if_req_valid,
   input  logic [31:0]   if_req_addr,
   output logic          if_req_ready,
   output logic          if_rsp_valid,
   output logic [31:0]   if_rsp_data,

   input  logic          dm_req_valid,
   input  t_core2mem_req dm_req,
   output logic          dm_req_ready,
   output logic          dm_rsp_valid,
   output logic [31:0]   dm_rsp_data,

   output logic          mem_req_valid,
   output t_core2mem_req mem_req,
   input  logic          mem_req_ready,
   input  logic          mem_rsp_valid,
   input  logic [31:0]   mem_rsp_data,

   output logic          rsp_err
);

   // Pointer width never drops to zero so a depth-1 FIFO still has a legal index.
   localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
   localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_OUTSTANDING);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(MAX_OUTSTANDING - 1);
   localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

   // Source tags stored in the FIFO and used for the round-robin history.
   localparam logic TAG_IF = 1'b0;
   localparam logic TAG_DM = 1'b1;

   typedef enum logic [1:0] {
      GRANT_IDLE = 2'd0,
      GRANT_IF   = 2'd1,
      GRANT_DM   = 2'd2
   } t_grant;

   t_grant              grant_q;

   logic                sel_dm;
   logic                sel_valid;
   t_core2mem_req       fetch_req;

   logic                fifo_full;
   logic                fifo_empty;
   logic                accept;
   logic                push;
   logic                pop;
   logic                head_tag;

   logic [MAX_OUTSTANDING-1:0] tag_mem_q;
   logic [PTR_W-1:0]           wr_ptr_q;
   logic [PTR_W-1:0]           rd_ptr_q;
   logic [CNT_W-1:0]           count_q;

`ifdef CORE_MEM_ARB_RR_EN
   logic                last_q;
`endif

   // Advance a FIFO pointer, wrapping after the last slot.
   function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] ptr);
      if (ptr == PTR_LAST) begin
         return '0;
      end
      return ptr + PTR_ONE;
   endfunction

   // A fetch is always a full-word read with no write data.
   always_comb begin
      fetch_req         = '0;
      fetch_req.addr    = if_req_addr;
      fetch_req.wr_data = '0;
      fetch_req.byte_en = 4'hF;
      fetch_req.rd_en   = 1'b1;
      fetch_req.wr_en   = 1'b0;
   end

   // Pick the source: a held grant wins outright, otherwise arbitrate live valids.
   always_comb begin
      sel_dm    = 1'b0;
      sel_valid = 1'b0;
      case (grant_q)
         GRANT_IF: begin
            sel_dm    = 1'b0;
            sel_valid = if_req_valid;
         end
         GRANT_DM: begin
            sel_dm    = 1'b1;
            sel_valid = dm_req_valid;
         end
         default: begin
            sel_valid = if_req_valid || dm_req_valid;
`ifdef CORE_MEM_ARB_RR_EN
            if (if_req_valid && dm_req_valid) begin
               sel_dm = (last_q == TAG_IF);
            end else begin
               sel_dm = dm_req_valid;
            end
`else
            sel_dm = dm_req_valid;
`endif
         end
      endcase
   end

   // FIFO status flags; a full FIFO blocks new requests even if it pops this cycle.
   assign fifo_full  = (count_q == CNT_MAX);
   assign fifo_empty = (count_q == '0);

   // Present the selected request to memory and steer the handshake back.
   always_comb begin
      mem_req_valid = sel_valid && !fifo_full;
      mem_req       = '0;
      if (sel_valid) begin
         mem_req = sel_dm ? dm_req : fetch_req;
      end
      accept       = mem_req_valid && mem_req_ready;
      if_req_ready = accept && !sel_dm;
      dm_req_ready = accept && sel_dm;
      push         = accept && (!sel_dm || dm_req.rd_en);
   end

   // Route returning read data by the oldest outstanding tag; idle outputs read 0.
   always_comb begin
      pop          = mem_rsp_valid && !fifo_empty;
      head_tag     = tag_mem_q[rd_ptr_q];
      if_rsp_valid = pop && (head_tag == TAG_IF);
      dm_rsp_valid = pop && (head_tag == TAG_DM);
      if_rsp_data  = if_rsp_valid ? mem_rsp_data : '0;
      dm_rsp_data  = dm_rsp_valid ? mem_rsp_data : '0;
   end

   // Hold the chosen source while memory stalls so the payload cannot switch mid-request.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         grant_q <= GRANT_IDLE;
      end else begin
         case (grant_q)
            GRANT_IDLE: begin
               if (sel_valid && !accept) begin
                  grant_q <= sel_dm ? GRANT_DM : GRANT_IF;
               end
            end
            default: begin
               if (accept) begin
                  grant_q <= GRANT_IDLE;
               end
            end
         endcase
      end
   end

`ifdef CORE_MEM_ARB_RR_EN
   // Remember who was served last so the other side wins the next tie.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_q <= TAG_IF;
      end else if (accept) begin
         last_q <= sel_dm ? TAG_DM : TAG_IF;
      end
   end
`endif

   // Tag FIFO storage and write pointer: one entry per accepted read.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tag_mem_q <= '0;
         wr_ptr_q  <= '0;
      end else if (push) begin
         tag_mem_q[wr_ptr_q] <= sel_dm ? TAG_DM : TAG_IF;
         wr_ptr_q            <= ptr_next(wr_ptr_q);
      end
   end

   // Read pointer advances on every response that has a matching tag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr_q <= '0;
      end else if (pop) begin
         rd_ptr_q <= ptr_next(rd_ptr_q);
      end
   end

   // Outstanding-read count; simultaneous push and pop leave it unchanged.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
      end else begin
         case ({push, pop})
            2'b10:   count_q <= count_q + CNT_ONE;
            2'b01:   count_q <= count_q - CNT_ONE;
            default: count_q <= count_q;
         endcase
      end
   end

   // Sticky flag for a response that nobody asked for; only reset clears it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_err <= 1'b0;
      end else if (mem_rsp_valid && fifo_empty) begin
         rsp_err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_core_mem_arbiter.sv
// tb_core_mem_arbiter: directed stimulus for core_mem_arbiter with a
// queue-based reference model compared every cycle, plus hand-computed
// literal expectations at key points of each scenario.

module tb_core_mem_arbiter;
   import core_mem_arbiter_pkg::*;

   localparam int MAX = 2;

   logic          clk;
   logic          rst_n;
   logic          if_req_valid;
   logic [31:0]   if_req_addr;
   logic          if_req_ready;
   logic          if_rsp_valid;
   logic [31:0]   if_rsp_data;
   logic          dm_req_valid;
   t_core2mem_req dm_req;
   logic          dm_req_ready;
   logic          dm_rsp_valid;
   logic [31:0]   dm_rsp_data;
   logic          mem_req_valid;
   t_core2mem_req mem_req;
   logic          mem_req_ready;
   logic          mem_rsp_valid;
   logic [31:0]   mem_rsp_data;
   logic          rsp_err;

   int errors = 0;
   int checks = 0;

   // Reference model state: 1 = fetch, 2 = data, 0 = none.
   int   held_src = 0;
   int   last_src = 1;
   bit   err_flag = 0;
   int   tagq[$];

   core_mem_arbiter #(.MAX_OUTSTANDING(MAX)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .if_req_valid  (if_req_valid),
      .if_req_addr   (if_req_addr),
      .if_req_ready  (if_req_ready),
      .if_rsp_valid  (if_rsp_valid),
      .if_rsp_data   (if_rsp_data),
      .dm_req_valid  (dm_req_valid),
      .dm_req        (dm_req),
      .dm_req_ready  (dm_req_ready),
      .dm_rsp_valid  (dm_rsp_valid),
      .dm_rsp_data   (dm_rsp_data),
      .mem_req_valid (mem_req_valid),
      .mem_req       (mem_req),
      .mem_req_ready (mem_req_ready),
      .mem_rsp_valid (mem_rsp_valid),
      .mem_rsp_data  (mem_rsp_data),
      .rsp_err       (rsp_err)
   );

   // Free-running clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check_output(input string name, input logic [127:0] actual,
                               input logic [127:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
      end
   endtask

   function automatic t_core2mem_req mk_req(input logic [31:0] addr, input logic [31:0] wd,
                                            input logic [3:0] be, input logic rd,
                                            input logic wr);
      t_core2mem_req r;
      r.addr    = addr;
      r.wr_data = wd;
      r.byte_en = be;
      r.rd_en   = rd;
      r.wr_en   = wr;
      return r;
   endfunction

   // Model compare: derive expected outputs from the arbitration rules, then advance.
   initial begin
      int            src;
      logic          sv;
      logic          emv;
      logic          acc;
      logic          rsp_if;
      logic          rsp_dm;
      t_core2mem_req ereq;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            held_src = 0;
            last_src = 1;
            err_flag = 0;
            tagq.delete();
            check_output("rst_rsp_err", 128'(rsp_err), 128'(0));
            check_output("rst_if_rsp_valid", 128'(if_rsp_valid), 128'(0));
            check_output("rst_dm_rsp_valid", 128'(dm_rsp_valid), 128'(0));
         end else begin
            if (held_src != 0) begin
               src = held_src;
            end else if (if_req_valid && dm_req_valid) begin
`ifdef CORE_MEM_ARB_RR_EN
               src = (last_src == 1) ? 2 : 1;
`else
               src = 2;
`endif
            end else if (dm_req_valid) begin
               src = 2;
            end else if (if_req_valid) begin
               src = 1;
            end else begin
               src = 0;
            end
            sv   = (src == 1) ? if_req_valid : (src == 2) ? dm_req_valid : 1'b0;
            emv  = sv && (tagq.size() < MAX);
            acc  = emv && mem_req_ready;
            ereq = (src == 1) ? mk_req(if_req_addr, 32'h0, 4'hF, 1'b1, 1'b0) : dm_req;
            rsp_if = mem_rsp_valid && (tagq.size() > 0) && (tagq[0] == 1);
            rsp_dm = mem_rsp_valid && (tagq.size() > 0) && (tagq[0] == 2);

            check_output("mem_req_valid", 128'(mem_req_valid), 128'(emv));
            if (emv) begin
               check_output("mem_req", 128'(mem_req), 128'(ereq));
            end
            check_output("if_req_ready", 128'(if_req_ready), 128'(acc && src == 1));
            check_output("dm_req_ready", 128'(dm_req_ready), 128'(acc && src == 2));
            check_output("if_rsp_valid", 128'(if_rsp_valid), 128'(rsp_if));
            check_output("dm_rsp_valid", 128'(dm_rsp_valid), 128'(rsp_dm));
            check_output("if_rsp_data", 128'(if_rsp_data), 128'(rsp_if ? mem_rsp_data : 32'h0));
            check_output("dm_rsp_data", 128'(dm_rsp_data), 128'(rsp_dm ? mem_rsp_data : 32'h0));
            check_output("rsp_err", 128'(rsp_err), 128'(err_flag));

            if (mem_rsp_valid) begin
               if (tagq.size() > 0) begin
                  void'(tagq.pop_front());
               end else begin
                  err_flag = 1;
               end
            end
            if (acc) begin
               if (src == 1 || dm_req.rd_en) begin
                  tagq.push_back(src);
               end
               last_src = src;
               held_src = 0;
            end else if (held_src == 0 && sv) begin
               held_src = src;
            end
         end
      end
   end

   // Drive one cycle of inputs just after the rising edge, return at the next falling edge.
   task automatic apply_stimulus(input logic ifv, input logic [31:0] ifa, input logic dmv,
                                 input t_core2mem_req dmr, input logic rdy,
                                 input logic rv, input logic [31:0] rd);
      @(posedge clk);
      #1;
      if_req_valid  = ifv;
      if_req_addr   = ifa;
      dm_req_valid  = dmv;
      dm_req        = dmr;
      mem_req_ready = rdy;
      mem_rsp_valid = rv;
      mem_rsp_data  = rd;
      @(negedge clk);
      #1;
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      if_req_valid  = 0;
      if_req_addr   = 0;
      dm_req_valid  = 0;
      dm_req        = '0;
      mem_req_ready = 1;
      mem_rsp_valid = 0;
      mem_rsp_data  = 0;
      rst_n         = 0;
      repeat (2) @(negedge clk);
      #1;
      check_output("reset_rsp_err", 128'(rsp_err), 128'(0));
      check_output("reset_mem_req_valid", 128'(mem_req_valid), 128'(0));
      @(posedge clk);
      #1;
      rst_n = 1;
   endtask

   // Watchdog so the run always ends.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout expected finish");
      $fatal(1, "[TB] timeout");
   end

   // Directed scenarios.
   initial begin
      t_core2mem_req z;
      t_core2mem_req ld100;
      t_core2mem_req ld300;
      t_core2mem_req st200;
      t_core2mem_req st400;
      z     = '0;
      ld100 = mk_req(32'h100, 32'h0, 4'hF, 1'b1, 1'b0);
      ld300 = mk_req(32'h300, 32'h0, 4'hF, 1'b1, 1'b0);
      st200 = mk_req(32'h200, 32'hCAFEF00D, 4'b0011, 1'b0, 1'b1);
      st400 = mk_req(32'h400, 32'h12345678, 4'hF, 1'b0, 1'b1);

      rst_n = 0;
      if_req_valid = 0; if_req_addr = 0; dm_req_valid = 0; dm_req = '0;
      mem_req_ready = 1; mem_rsp_valid = 0; mem_rsp_data = 0;
      do_reset();

      $display("[TB] fetch-only stream with full FIFO");
      apply_stimulus(1, 32'h0, 0, z, 1, 0, 0);
      check_output("t1_accept0", 128'(if_req_ready), 128'(1));
      check_output("t1_addr0", 128'(mem_req.addr), 128'(32'h0));
      apply_stimulus(1, 32'h4, 0, z, 1, 0, 0);
      check_output("t1_accept4", 128'(if_req_ready), 128'(1));
      apply_stimulus(1, 32'h8, 0, z, 1, 0, 0);
      check_output("t1_full_stall", 128'(mem_req_valid), 128'(0));
      apply_stimulus(1, 32'h8, 0, z, 1, 1, 32'h11111111);
      check_output("t1_rsp1_data", 128'(if_rsp_data), 128'(32'h11111111));
      check_output("t1_full_pop_stall", 128'(mem_req_valid), 128'(0));
      apply_stimulus(1, 32'h8, 0, z, 1, 1, 32'h22222222);
      check_output("t1_rsp2_data", 128'(if_rsp_data), 128'(32'h22222222));
      check_output("t1_accept8", 128'(if_req_ready), 128'(1));
      apply_stimulus(0, 32'h0, 0, z, 1, 1, 32'h33333333);
      check_output("t1_rsp3_valid", 128'(if_rsp_valid), 128'(1));

      $display("[TB] simultaneous fetch and data load");
      apply_stimulus(1, 32'h20, 1, ld100, 1, 0, 0);
      check_output("t2_dm_first", 128'(dm_req_ready), 128'(1));
      check_output("t2_if_waits", 128'(if_req_ready), 128'(0));
      check_output("t2_addr", 128'(mem_req.addr), 128'(32'h100));
      apply_stimulus(1, 32'h20, 0, z, 1, 0, 0);
      check_output("t2_if_next", 128'(if_req_ready), 128'(1));
      apply_stimulus(0, 32'h0, 0, z, 1, 1, 32'hAAAA0000);
      check_output("t2_dm_rsp", 128'(dm_rsp_data), 128'(32'hAAAA0000));
      check_output("t2_if_quiet", 128'(if_rsp_valid), 128'(0));
      apply_stimulus(0, 32'h0, 0, z, 1, 1, 32'hBBBB0000);
      check_output("t2_if_rsp", 128'(if_rsp_data), 128'(32'hBBBB0000));
      check_output("t2_dm_zero", 128'(dm_rsp_data), 128'(0));

      $display("[TB] data store passes through");
      apply_stimulus(0, 32'h0, 1, st200, 1, 0, 0);
      check_output("t3_payload", 128'(mem_req), 128'(st200));
      check_output("t3_ready", 128'(dm_req_ready), 128'(1));
      apply_stimulus(0, 32'h0, 0, z, 1, 0, 0);

      $display("[TB] memory stall holds fetch grant");
      apply_stimulus(1, 32'h40, 0, z, 0, 0, 0);
      check_output("t4_valid_stall", 128'(mem_req_valid), 128'(1));
      apply_stimulus(1, 32'h40, 0, z, 0, 0, 0);
      apply_stimulus(1, 32'h40, 0, z, 0, 0, 0);
      apply_stimulus(1, 32'h40, 1, ld300, 0, 0, 0);
      check_output("t4_held_addr", 128'(mem_req.addr), 128'(32'h40));
      apply_stimulus(1, 32'h40, 1, ld300, 1, 0, 0);
      check_output("t4_if_first", 128'(if_req_ready), 128'(1));
      check_output("t4_dm_blocked", 128'(dm_req_ready), 128'(0));
      apply_stimulus(0, 32'h0, 1, ld300, 1, 0, 0);
      check_output("t4_dm_second", 128'(dm_req_ready), 128'(1));
      apply_stimulus(0, 32'h0, 0, z, 1, 1, 32'h44444444);
      check_output("t4_if_rsp", 128'(if_rsp_data), 128'(32'h44444444));
      apply_stimulus(0, 32'h0, 0, z, 1, 1, 32'h55555555);
      check_output("t4_dm_rsp", 128'(dm_rsp_data), 128'(32'h55555555));

      $display("[TB] unexpected response sets sticky error");
      apply_stimulus(0, 32'h0, 0, z, 1, 1, 32'h66666666);
      check_output("t5_no_if_rsp", 128'(if_rsp_valid), 128'(0));
      check_output("t5_no_dm_rsp", 128'(dm_rsp_valid), 128'(0));
      apply_stimulus(0, 32'h0, 0, z, 1, 0, 0);
      check_output("t5_err_set", 128'(rsp_err), 128'(1));
      apply_stimulus(0, 32'h0, 0, z, 1, 0, 0);
      check_output("t5_err_sticky", 128'(rsp_err), 128'(1));

      $display("[TB] reset discards outstanding tags");
      apply_stimulus(1, 32'h90, 0, z, 1, 0, 0);
      check_output("t6_accept", 128'(if_req_ready), 128'(1));
      do_reset();
      apply_stimulus(0, 32'h0, 0, z, 1, 1, 32'h77777777);
      check_output("t6_orphan_if", 128'(if_rsp_valid), 128'(0));
      apply_stimulus(0, 32'h0, 0, z, 1, 0, 0);
      check_output("t6_orphan_err", 128'(rsp_err), 128'(1));
      do_reset();

      $display("[TB] continuous contention");
      for (int i = 0; i < 4; i++) begin
         apply_stimulus(1, 32'h80, 1, st400, 1, 0, 0);
`ifdef CORE_MEM_ARB_RR_EN
         check_output("t7_rr_dm", 128'(dm_req_ready), 128'((i % 2) == 0));
         check_output("t7_rr_if", 128'(if_req_ready), 128'((i % 2) == 1));
`else
         check_output("t7_fix_dm", 128'(dm_req_ready), 128'(1));
         check_output("t7_fix_if", 128'(if_req_ready), 128'(0));
`endif
      end
      for (int i = 0; i < 4; i++) begin
         if (tagq.size() > 0) begin
            apply_stimulus(0, 32'h0, 0, z, 1, 1, 32'h88880000 + 32'(i));
         end else begin
            apply_stimulus(0, 32'h0, 0, z, 1, 0, 0);
         end
      end
      apply_stimulus(0, 32'h0, 0, z, 1, 0, 0);
      check_output("t7_no_err", 128'(rsp_err), 128'(0));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/core_mem_arbiter.md
# core_mem_arbiter

Shares one memory port between instruction fetch (Q100H) and data access (Q103H), producing a single `t_core2mem_req` stream and routing read data back to whichever requester issued the read. Sits between the fetch/memory-access stages and the unified memory. Tracks up to `MAX_OUTSTANDING` in-order reads with a tag FIFO. Generates stall backpressure via per-requester ready signals.

## Interface
- `MAX_OUTSTANDING`, 2: maximum accepted-but-unanswered reads; power of two, 1..8.
- `clk`  in  1  core clock.
- `rst_n`  in  1  asynchronous reset, active-low.
- `if_req_valid`  in  1  fetch read request.
- `if_req_addr`  in  32  fetch address (word-aligned).
- `if_req_ready`  out  1  fetch request accepted this cycle.
- `if_rsp_valid`  out  1  fetch read data valid.
- `if_rsp_data`  out  32  fetch read data.
- `dm_req_valid`  in  1  data request.
- `dm_req`  in  `t_core2mem_req`  data request payload (wr_en/rd_en exclusive).
- `dm_req_ready`  out  1  data request accepted this cycle.
- `dm_rsp_valid`  out  1  load data valid.
- `dm_rsp_data`  out  32  load data.
- `mem_req_valid`  out  1  request to memory.
- `mem_req`  out  `t_core2mem_req`  request payload.
- `mem_req_ready`  in  1  memory accepts request.
- `mem_rsp_valid`  in  1  read data return (in order, no backpressure).
- `mem_rsp_data`  in  32  read data.
- `rsp_err`  out  1  sticky: response arrived with no outstanding read.

## Operation
- Accept = `mem_req_valid && mem_req_ready`. `if_req_ready`/`dm_req_ready` = accept && granted source.
- Grant state `grant_q` (IDLE, IF, DM). In IDLE, selection made combinationally from valid inputs; if not accepted, selection registered into `grant_q` and held (payload, source) until accept, then back to IDLE. Held payload is from the requester's still-asserted inputs; requesters must hold valid/payload stable until ready.
- Priority (default): data over fetch.
- `mem_req_valid` = selected valid && `count < MAX_OUTSTANDING`. When full, no request presented, even if a response pops the FIFO the same cycle.
- Fetch payload: address = `if_req_addr`, rd_en=1, wr_en=0, byte_en=4'hF, wr_data=0. Data payload forwarded unmodified.
- Tag FIFO (1-bit source, depth `MAX_OUTSTANDING`): push on accepted read (fetch, or data with rd_en); writes push nothing. Pop on `mem_rsp_valid`.
- On `mem_rsp_valid` with FIFO non-empty: route to `if_rsp_*` or `dm_rsp_*` per head tag, same cycle (combinational). Unused rsp_data outputs drive 0.
- On `mem_rsp_valid` with FIFO empty: response dropped, `rsp_err` set until reset.
- Simultaneous push and pop: count unchanged, both pointers advance.

## Timing
- Reset (async assert, sync deassert in clk domain): `grant_q`=IDLE, FIFO empty, count=0, `rsp_err`=0; all outputs 0.
- Request path: zero-latency combinational from requester valid to `mem_req_valid`/payload.
- Response path: zero-latency from `mem_rsp_valid` to requester rsp_valid.
- Max issue rate: one request per cycle while count < MAX_OUTSTANDING.
- Reset mid-transaction discards outstanding tags; later responses set `rsp_err`.

## Configuration
- `CORE_MEM_ARB_RR_EN`: defined -> round-robin; a 1-bit `last_q` (reset: IF) records last granted source, and on contention the other source wins. Not defined -> fixed data-over-fetch priority, no `last_q` register.

## Test plan
- Fetch only, `MAX_OUTSTANDING`=2, mem_req_ready=1: reads at 0x0, 0x4, 0x8 -> two accepted back-to-back, third stalls until first response; responses 0x11111111, 0x22222222 appear on `if_rsp_data` in order.
- Both valid in same cycle (fixed priority): data load 0x100 and fetch 0x20 -> data granted first, fetch next cycle; responses routed DM then IF.
- Data store 0x200, byte_en 4'b0011 -> mem_req mirrors payload, no FIFO push, count stays 0, no response expected.
- mem_req_ready=0 for 3 cycles while fetch waits, then data becomes valid -> grant stays IF, payload stable, fetch accepted first.
- `mem_rsp_valid` with count=0 -> no rsp_valid on either side, `rsp_err`=1 until `rst_n` low.
- With `CORE_MEM_ARB_RR_EN`, both valid continuously -> grants alternate DM, IF, DM, IF starting with DM.
